// File: rtl/contrast_status_pkg.sv
// Shared field layout, state encoding and word builders for the contrast box
// status sequencer.
package contrast_status_pkg;

  localparam int unsigned WORD_W      = 18;
  localparam int unsigned VAL_W       = 10;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned NBOX_W      = 4;
  localparam int unsigned SEQ_FIELD_W = 10;

  localparam logic [1:0] HDR_MARK  = 2'b10;
  localparam logic [1:0] DATA_MARK = 2'b01;

  localparam logic [1:0] CAUSE_CHANGE   = 2'b01;
  localparam logic [1:0] CAUSE_PERIODIC = 2'b10;

  // Bit positions shared by header and data words
  localparam int unsigned MARK_LSB  = 16;
  localparam int unsigned CAUSE_LSB = 14;
  localparam int unsigned NBOX_LSB  = 10;
  localparam int unsigned SEQ_LSB   = 0;
  localparam int unsigned BOX_LSB   = 13;
  localparam int unsigned VAL_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } state_t;

  function automatic logic [WORD_W-1:0] make_header(
    input logic [1:0]             cause,
    input logic [NBOX_W-1:0]      nbox,
    input logic [SEQ_FIELD_W-1:0] seq
  );
    logic [WORD_W-1:0] w;
    w = '0;
    w[MARK_LSB +: 2]            = HDR_MARK;
    w[CAUSE_LSB +: 2]           = cause;
    w[NBOX_LSB +: NBOX_W]       = nbox;
    w[SEQ_LSB +: SEQ_FIELD_W]   = seq;
    return w;
  endfunction

  // Bits [12:10] of a data word are reserved and stay zero
  function automatic logic [WORD_W-1:0] make_data(
    input logic [IDX_W-1:0] box,
    input logic [VAL_W-1:0] value
  );
    logic [WORD_W-1:0] w;
    w = '0;
    w[MARK_LSB +: 2]     = DATA_MARK;
    w[BOX_LSB +: IDX_W]  = box;
    w[VAL_LSB +: VAL_W]  = value;
    return w;
  endfunction

endpackage

// File: rtl/contrast_status_snapshot.sv
// Shadow register bank: freezes all PWM on-values on load so a frame reports
// one coherent set of values regardless of later input changes.
module contrast_status_snapshot
  import contrast_status_pkg::*;
#(
  parameter int NUMBER_OF_BOXES = 2,
  parameter int PWM_REG_WIDTH   = 10
) (
  input  logic                                     clk_peri,
  input  logic                                     load,
  input  logic [PWM_REG_WIDTH*NUMBER_OF_BOXES-1:0] pwm_on_time,
  input  logic [IDX_W-1:0]                         sel,
  output logic [PWM_REG_WIDTH-1:0]                 value
);

  logic [PWM_REG_WIDTH-1:0] shadow [NUMBER_OF_BOXES];

  // Pure data storage: only ever read after a load, so no reset needed
  always_ff @(posedge clk_peri) begin
    if (load) begin
      for (int k = 0; k < NUMBER_OF_BOXES; k++) begin
        shadow[k] <= pwm_on_time[k*PWM_REG_WIDTH +: PWM_REG_WIDTH];
      end
    end
  end

  always_comb begin
    value = '0;
    for (int k = 0; k < NUMBER_OF_BOXES; k++) begin
      if (sel == IDX_W'(k)) value = shadow[k];
    end
  end

endmodule

// File: rtl/contrast_status_sequencer.sv
// Status frame scheduler: snapshots PWM on-values on a trigger and streams
// header + per-box data words, merging overlapping triggers into one pending frame.
module contrast_status_sequencer
  import contrast_status_pkg::*;
#(
  parameter int NUMBER_OF_BOXES = 2,
  parameter int PWM_REG_WIDTH   = 10,
  parameter int SEQ_WIDTH       = 10
) (
  input  logic                                     clk_peri,
  input  logic                                     reset,
  input  logic                                     enable,
  input  logic                                     trigger_change,
  input  logic                                     trigger_periodic,
  input  logic [PWM_REG_WIDTH*NUMBER_OF_BOXES-1:0] pwm_on_time,
  output logic [WORD_W-1:0]                        out_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic                                     busy,
  output logic                                     overrun,
  input  logic                                     overrun_clr
);

  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUMBER_OF_BOXES - 1);
  localparam logic [NBOX_W-1:0] NBOX_FIELD = NBOX_W'(NUMBER_OF_BOXES);

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic [IDX_W-1:0]         sel;
  logic [SEQ_WIDTH-1:0]     seq;
  logic [SEQ_FIELD_W-1:0]   seq_field;
  logic                     pending;
  logic [1:0]               pending_cause;
  logic [1:0]               cause;
  logic [1:0]               start_cause;
  logic                     accept;
  logic                     handshake;
  logic                     last_handshake;
  logic                     start_frame;
  logic                     overrun_set;
  logic [VAL_W-1:0]         snap_value;

  assign cause = (trigger_change   ? CAUSE_CHANGE   : 2'b00) |
                 (trigger_periodic ? CAUSE_PERIODIC : 2'b00);

  assign accept         = enable && (cause != 2'b00);
  assign handshake      = out_valid && out_ready;
  assign last_handshake = (state == ST_DATA) && handshake && (idx == LAST_IDX);
  assign seq_field      = SEQ_FIELD_W'(seq);

  // A trigger landing on the final handshake edge folds straight into the
  // next frame, so the pending request and that trigger are merged here.
  assign start_frame = (state == ST_IDLE) ? accept
                                          : (last_handshake && (pending || accept));
  assign start_cause = (state == ST_IDLE) ? cause
                                          : ((pending ? pending_cause : 2'b00) |
                                             (accept  ? cause         : 2'b00));

  assign overrun_set = accept && (state != ST_IDLE) && pending;

  // Next box to present: box 0 after the header, idx+1 while in DATA
  assign sel = (state == ST_DATA) ? idx + IDX_W'(1) : '0;

  contrast_status_snapshot #(
    .NUMBER_OF_BOXES (NUMBER_OF_BOXES),
    .PWM_REG_WIDTH   (PWM_REG_WIDTH)
  ) snapshot (
    .clk_peri    (clk_peri),
    .load        (start_frame),
    .pwm_on_time (pwm_on_time),
    .sel         (sel),
    .value       (snap_value)
  );

  always_ff @(posedge clk_peri or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      idx           <= '0;
      seq           <= '0;
      pending       <= 1'b0;
      pending_cause <= 2'b00;
      out_valid     <= 1'b0;
      out_data      <= '0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      busy <= start_frame || ((state != ST_IDLE) && !last_handshake);

      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end

      if (start_frame) seq <= seq + SEQ_WIDTH'(1);

      if (last_handshake) begin
        pending       <= 1'b0;
        pending_cause <= 2'b00;
      end else if (accept && (state != ST_IDLE)) begin
        pending       <= 1'b1;
        pending_cause <= pending ? (pending_cause | cause) : cause;
      end

      if (start_frame) begin
        state     <= ST_HEADER;
        idx       <= '0;
        out_valid <= 1'b1;
        out_data  <= make_header(start_cause, NBOX_FIELD, seq_field);
      end else begin
        case (state)
          ST_HEADER: begin
            if (handshake) begin
              state    <= ST_DATA;
              idx      <= '0;
              out_data <= make_data(sel, snap_value);
            end
          end
          ST_DATA: begin
            if (handshake) begin
              if (idx == LAST_IDX) begin
                state     <= ST_IDLE;
                out_valid <= 1'b0;
              end else begin
                idx      <= sel;
                out_data <= make_data(sel, snap_value);
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/contrast_status_sequencer.md
Name: contrast_status_sequencer

Overview:
- Schedules status reporting for the contrast box array.
- Accepts change and periodic triggers and takes a coherent snapshot of all PWM on-values.
- Serialises the snapshot as one framed burst of 18-bit words over a valid/ready stream to the logger/UART sink.
- Arbitrates overlapping triggers: merges them and flags lost frames, so that the downstream sink sees at most one frame in flight plus one pending.

Parameters:
- NUMBER_OF_BOXES, 2, number of boxes reported per frame; legal range 1..8.
- PWM_REG_WIDTH, 10, width of each on-value; fixed at 10 (data field width).
- SEQ_WIDTH, 10, width of the frame sequence counter.

Ports:
- clk_peri  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- enable  in  1  trigger acceptance enable.
- trigger_change  in  1  single-cycle pulse: some on-value changed.
- trigger_periodic  in  1  single-cycle pulse: periodic status tick.
- pwm_on_time  in  PWM_REG_WIDTH*NUMBER_OF_BOXES  packed on-values; box k occupies bits [10k+9:10k].
- out_data  out  18  stream word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts the word.
- busy  out  1  frame in progress or pending.
- overrun  out  1  sticky: a trigger was merged into an already pending request.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset (async) values:
  - out_valid=0, out_data=0, busy=0, overrun=0.
  - seq=0, pending=0, pending_cause=0.
  - State=IDLE.
- cause[1:0] = {trigger_periodic, trigger_change}.
- A trigger is "accepted" when enable=1 and cause is non-zero. With enable=0, triggers are ignored; a frame already in progress or pending still completes.
- Header word:
  - [17:16]=2'b10.
  - [15:14]=cause.
  - [13:10]=NUMBER_OF_BOXES.
  - [9:0]=seq.
- Data word:
  - [17:16]=2'b01.
  - [15:13]=box index.
  - [12:10]=0.
  - [9:0]=snapshot value.
- States: IDLE, HEADER, DATA.
- IDLE: when a trigger is accepted at edge t:
  - The same edge latches all on-values into shadow registers.
  - Loads the header (with the current seq); seq increments, wrapping 2^SEQ_WIDTH-1 -> 0.
  - out_valid=1; state=HEADER.
  - The header is therefore visible in the cycle after the trigger (latency 1).
- HEADER: on out_valid&&out_ready, present data word for box 0; state=DATA; idx=0.
- DATA: on each handshake, idx+1 and present the next box. The handshake on idx=NUMBER_OF_BOXES-1 ends the frame:
  - If pending=1: snapshot, header with pending_cause, seq increment and pending clear all occur on that same edge; state=HEADER (back-to-back, no idle cycle).
  - Else: out_valid=0; state=IDLE.
- Accepted trigger while state!=IDLE:
  - If pending=0: pending=1, pending_cause=cause.
  - If pending=1: pending_cause |= cause; overrun=1.
  - A trigger on the frame's final handshake edge counts as pending, i.e. it is merged with or becomes the next frame.
- Handshake rule: out_data and out_valid stay stable while out_valid=1 and out_ready=0. The snapshot never changes mid-frame.
- busy = (state!=IDLE) || pending.
- overrun_clr: clears overrun. If overrun_clr and an overrun event occur on the same edge, the set wins.
- NUMBER_OF_BOXES=1: frame = header + one data word.
- Frame length = NUMBER_OF_BOXES+1 words. With out_ready held high, the minimum frame duration is NUMBER_OF_BOXES+1 cycles.

Decomposition:
- Shared package contrast_status_pkg holds:
  - HDR_MARK=2'b10, DATA_MARK=2'b01.
  - Field bit positions.
  - State encoding constants (IDLE/HEADER/DATA).
  - Cause encodings: CAUSE_CHANGE=2'b01, CAUSE_PERIODIC=2'b10.
- One sub-module: contrast_status_snapshot, the shadow register bank. It has a load strobe, packed input, and an index-selected 10-bit output.
- The FSM, seq counter and pending/overrun logic stay in the top module.

Test Plan:
- Single change trigger, NUMBER_OF_BOXES=2, values 0x155/0x2AA, out_ready=1:
  - Header 0x2_4800 with cause=01, seq=0 appears 1 cycle later.
  - Then 0x1_0155, then 0x1_22AA.
  - out_valid drops after 3 words; busy=0.
- Backpressure: out_ready=0 for 5 cycles mid-frame and pwm_on_time changed during the stall → out_data is held; the words emitted carry the pre-change snapshot.
- Trigger during frame, then a second trigger (periodic) during the same frame:
  - Overrun=1.
  - Next frame starts on the edge of the last data handshake, with cause=11 and seq=1.
- Simultaneous trigger_change and trigger_periodic while idle → header cause=11.
  - enable=0 with triggers → no output, busy=0.
- Assert reset mid-DATA → out_valid=0 immediately (async); seq=0, pending=0; the next trigger yields seq=0.
- 1024 frames → seq wraps from 1023 to 0.
  - overrun_clr asserted on the same edge as an overrun event → overrun stays 1.
